hazard_unit_mc: RTL and testbench

//  Hazard/forwarding controller for the 5-stage MIPS pipeline with multi-cycle resources.

---
 rtl/hazard_pkg.sv | 21 ++
 rtl/hazard_div_tracker.sv | 31 +++
 rtl/hazard_unit_mc.sv | 160 ++++++++++++++++
 tb/tb_hazard_unit_mc.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared encodings and helpers for the multi-cycle hazard/forwarding controller.
package hazard_pkg;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    localparam int unsigned DIV_LAT_DEFAULT = 8;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_WAIT = 2'd1,
        MEM_ERR  = 2'd2
    } mem_state_t;

    // Width of the divider latency down-counter: it must hold DIV_LAT itself.
    function automatic int unsigned divCntWidth(input int unsigned divLat);
        return $clog2(divLat + 1);
    endfunction

endpackage

// File: rtl/hazard_div_tracker.sv
// Divider busy tracker: busy for exactly DIV_LAT cycles after an accepted start.
module hazard_div_tracker
    import hazard_pkg::*;
#(
    parameter int unsigned DIV_LAT = DIV_LAT_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic busy
);

    localparam int unsigned DIV_CNT_W = divCntWidth(DIV_LAT);

    logic [DIV_CNT_W-1:0] remaining;

    // A start while busy simply reloads the full latency.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            remaining <= '0;
            busy      <= 1'b0;
        end else if (start) begin
            remaining <= DIV_CNT_W'(DIV_LAT);
            busy      <= 1'b1;
        end else if (remaining != '0) begin
            remaining <= remaining - DIV_CNT_W'(1);
            busy      <= (remaining != DIV_CNT_W'(1));
        end
    end

endmodule

// File: rtl/hazard_unit_mc.sv
// Hazard/forwarding controller for the 5-stage MIPS pipeline with multi-cycle resources.
// Optional perf counters enabled by defining HAZARD_PERF_EN.
module hazard_unit_mc
    import hazard_pkg::*;
#(
    parameter int unsigned REG_W       = 5,
    parameter int unsigned DIV_LAT     = 8,
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] rsD,
    input  logic [REG_W-1:0] rtD,
    input  logic [REG_W-1:0] rsE,
    input  logic [REG_W-1:0] rtE,
    input  logic [REG_W-1:0] writeregE,
    input  logic [REG_W-1:0] writeregM,
    input  logic [REG_W-1:0] writeregW,
    input  logic             regwriteE,
    input  logic             regwriteM,
    input  logic             regwriteW,
    input  logic             memtoregE,
    input  logic             memtoregM,
    input  logic             branchD,
    input  logic             memreqM,
    input  logic             dmem_ready,
    input  logic             divstartE,
    input  logic             mfhiloD,
    output logic [1:0]       forwardaE,
    output logic [1:0]       forwardbE,
    output logic             forwardaD,
    output logic             forwardbD,
    output logic             stallF,
    output logic             stallD,
    output logic             stallE,
    output logic             stallM,
    output logic             flushE,
    output logic             div_busy,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam int unsigned MEM_CNT_W = $clog2(MEM_TIMEOUT);
    localparam logic [MEM_CNT_W-1:0] MEM_LAST = MEM_CNT_W'(MEM_TIMEOUT - 1);

    mem_state_t           memState;
    logic [MEM_CNT_W-1:0] waitCnt;
    logic                 memStall;
    logic                 lwStall;
    logic                 brStall;
    logic                 divStall;
    logic                 depStall;
    logic                 divAccept;

    // Forwarding selects; M wins over W and register 0 never forwards.
    always_comb begin
        forwardaE = FWD_RF;
        forwardbE = FWD_RF;
        forwardaD = 1'b0;
        forwardbD = 1'b0;
        if (rst_n) begin
            if (rsE != '0 && regwriteM && writeregM == rsE)      forwardaE = FWD_M;
            else if (rsE != '0 && regwriteW && writeregW == rsE) forwardaE = FWD_W;
            if (rtE != '0 && regwriteM && writeregM == rtE)      forwardbE = FWD_M;
            else if (rtE != '0 && regwriteW && writeregW == rtE) forwardbE = FWD_W;
            forwardaD = (rsD != '0) && regwriteM && (writeregM == rsD);
            forwardbD = (rtD != '0) && regwriteM && (writeregM == rtD);
        end
    end

    always_comb begin
        lwStall  = 1'b0;
        brStall  = 1'b0;
        divStall = 1'b0;
        memStall = 1'b0;
        if (rst_n) begin
            lwStall = memtoregE && (writeregE != '0)
                   && (writeregE == rsD || writeregE == rtD);
            brStall = branchD
                   && ((regwriteE && (writeregE != '0) && (writeregE == rsD || writeregE == rtD))
                    || (memtoregM && (writeregM != '0) && (writeregM == rsD || writeregM == rtD)));
            divStall = mfhiloD && (div_busy || divstartE);
            memStall = memreqM && !dmem_ready && (memState != MEM_ERR);
        end
    end

    // A memory wait freezes the whole front of the pipe; E is held rather than bubbled.
    always_comb begin
        depStall = lwStall || brStall || divStall;
        stallF   = memStall || depStall;
        stallD   = memStall || depStall;
        stallE   = memStall;
        stallM   = memStall;
        flushE   = depStall && !memStall;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            memState <= MEM_IDLE;
            waitCnt  <= '0;
            mem_err  <= 1'b0;
        end else begin
            case (memState)
                MEM_IDLE: begin
                    if (memStall) begin
                        memState <= MEM_WAIT;
                        waitCnt  <= MEM_CNT_W'(1);
                    end
                end
                MEM_WAIT: begin
                    if (dmem_ready) begin
                        memState <= MEM_IDLE;
                        waitCnt  <= '0;
                    end else if (waitCnt == MEM_LAST) begin
                        memState <= MEM_ERR;
                        mem_err  <= 1'b1;
                    end else begin
                        waitCnt <= waitCnt + MEM_CNT_W'(1);
                    end
                end
                MEM_ERR: begin
                    mem_err <= 1'b1;
                end
                default: begin
                    memState <= MEM_IDLE;
                    waitCnt  <= '0;
                end
            endcase
        end
    end

    assign divAccept = divstartE && !stallE;

    hazard_div_tracker #(
        .DIV_LAT(DIV_LAT)
    ) u_div_tracker (
        .clk  (clk),
        .rst_n(rst_n),
        .start(divAccept),
        .busy (div_busy)
    );

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (stallF) stall_cycles <= stall_cycles + CNT_W'(1);
            if (flushE) flush_count  <= flush_count + CNT_W'(1);
        end
    end
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Scoreboard bench for hazard_unit_mc: directed scenarios then random traffic vs a cycle-level model.
module tb_hazard_unit_mc;

    localparam int unsigned REG_W       = 5;
    localparam int unsigned DIV_LAT     = 8;
    localparam int unsigned MEM_TIMEOUT = 4;
    localparam int unsigned CNT_W       = 32;

    logic clk = 1'b0;
    logic rst_n;
    logic [REG_W-1:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
    logic regwriteE, regwriteM, regwriteW, memtoregE, memtoregM;
    logic branchD, memreqM, dmem_ready, divstartE, mfhiloD;
    logic [1:0] forwardaE, forwardbE;
    logic forwardaD, forwardbD, stallF, stallD, stallE, stallM, flushE, div_busy, mem_err;
    logic [CNT_W-1:0] stall_cycles, flush_count;

    always #5 clk = ~clk;

    hazard_unit_mc #(
        .REG_W(REG_W), .DIV_LAT(DIV_LAT), .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
        .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
        .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
        .memtoregE(memtoregE), .memtoregM(memtoregM),
        .branchD(branchD), .memreqM(memreqM), .dmem_ready(dmem_ready),
        .divstartE(divstartE), .mfhiloD(mfhiloD),
        .forwardaE(forwardaE), .forwardbE(forwardbE),
        .forwardaD(forwardaD), .forwardbD(forwardbD),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
        .flushE(flushE), .div_busy(div_busy), .mem_err(mem_err),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    typedef struct packed {
        logic [1:0]  fAE;
        logic [1:0]  fBE;
        logic        fAD, fBD, sF, sD, sE, sM, fE, busy, err;
        logic [31:0] sc;
        logic [31:0] fc;
    } outVec_t;

    outVec_t expQ[$];
    string   tagQ[$];
    int      vectors    = 0;
    int      miscompares = 0;

    // Reference model state
    int          cycleNo     = 0;
    int          divLastBusy = -1;
    int          waitLen     = 0;
    bit          errFlag     = 1'b0;
    int unsigned stallCnt    = 0;
    int unsigned flushCnt    = 0;

    function automatic logic [1:0] fwdE(input logic [REG_W-1:0] src);
        if (src == 0) return 2'b00;
        if (regwriteM && writeregM == src) return 2'b10;
        if (regwriteW && writeregW == src) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit hits(input logic [REG_W-1:0] dst);
        return (dst != 0) && (dst == rsD || dst == rtD);
    endfunction

    // Predict this cycle's outputs, queue them, then advance the model past the clock edge.
    task automatic step(input string tag);
        outVec_t e;
        bit memStall, lw, br, dv, dep;
        e = '0;
        memStall = 1'b0;
        e.busy = (cycleNo <= divLastBusy);
        e.err  = errFlag;
`ifdef HAZARD_PERF_EN
        e.sc = stallCnt;
        e.fc = flushCnt;
`endif
        if (rst_n) begin
            e.fAE = fwdE(rsE);
            e.fBE = fwdE(rtE);
            e.fAD = (rsD != 0) && regwriteM && (writeregM == rsD);
            e.fBD = (rtD != 0) && regwriteM && (writeregM == rtD);
            memStall = memreqM && !dmem_ready && !errFlag;
            lw  = memtoregE && hits(writeregE);
            br  = branchD && ((regwriteE && hits(writeregE)) || (memtoregM && hits(writeregM)));
            dv  = mfhiloD && (e.busy || divstartE);
            dep = lw || br || dv;
            e.sF = memStall || dep;
            e.sD = memStall || dep;
            e.sE = memStall;
            e.sM = memStall;
            e.fE = dep && !memStall;
        end
        expQ.push_back(e);
        tagQ.push_back(tag);
        if (!rst_n) begin
            divLastBusy = -1;
            waitLen  = 0;
            errFlag  = 1'b0;
            stallCnt = 0;
            flushCnt = 0;
        end else begin
            if (divstartE && !e.sE) divLastBusy = cycleNo + int'(DIV_LAT);
            if (memStall) begin
                waitLen++;
                if (waitLen == int'(MEM_TIMEOUT)) errFlag = 1'b1;
            end else begin
                waitLen = 0;
            end
            stallCnt += 32'(e.sF);
            flushCnt += 32'(e.fE);
        end
        cycleNo++;
        @(negedge clk);
    endtask

    task automatic clearInputs();
        rsD = '0; rtD = '0; rsE = '0; rtE = '0;
        writeregE = '0; writeregM = '0; writeregW = '0;
        regwriteE = 0; regwriteM = 0; regwriteW = 0;
        memtoregE = 0; memtoregM = 0; branchD = 0;
        memreqM = 0; dmem_ready = 0; divstartE = 0; mfhiloD = 0;
    endtask

    task automatic doReset();
        rst_n = 0;
        step("reset");
        rst_n = 1;
    endtask

    // Monitor: compare every presented output vector against the queued prediction.
    initial begin : monitor
        outVec_t e, a;
        string   t;
        forever begin
            @(negedge clk);
            #2;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                t = tagQ.pop_front();
                a = {forwardaE, forwardbE, forwardaD, forwardbD, stallF, stallD, stallE,
                     stallM, flushE, div_busy, mem_err, 32'(stall_cycles), 32'(flush_count)};
                vectors++;
                if (a !== e) begin
                    miscompares++;
                    $display("FAIL %s @%0t: got %h expected %h", t, $time, a, e);
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: bench did not finish, vectors=%0d", vectors);
        $fatal(1, "timeout");
    end

    initial begin : driver
        int memLat;
        bit inEp;
        inEp = 0;
        memLat = 0;
        clearInputs();
        rst_n = 0;
        @(negedge clk);
        @(negedge clk);
        doReset();

        // Forwarding
        rsE = 7; writeregM = 7; writeregW = 7; regwriteM = 1; regwriteW = 1;
        step("fwd_m_beats_w");
        writeregM = 8;
        step("fwd_from_w");
        rtE = 8;
        step("fwd_b_from_m");
        rsE = 0; rtE = 0; writeregM = 0; writeregW = 0;
        step("fwd_reg0");
        clearInputs();

        // Branch compare dependency, then producer moves to M
        branchD = 1; regwriteE = 1; writeregE = 5; rsD = 5;
        step("br_stall");
        regwriteE = 0; writeregE = 0; regwriteM = 1; writeregM = 5;
        step("br_fwd_d");
        clearInputs();

        // Load-use then memory wait, counters start from a fresh reset
        doReset();
        memtoregE = 1; writeregE = 7; rtD = 7;
        step("lw_stall");
        writeregE = 0;
        step("lw_reg0");
        memreqM = 1; dmem_ready = 0; writeregE = 7;
        repeat (3) step("mem_wait");
        memtoregE = 0; writeregE = 0; rtD = 0; dmem_ready = 1;
        step("mem_done");
        clearInputs();
        step("perf_after_mem");

        // Memory timeout and sticky error
        memreqM = 1; dmem_ready = 0;
        repeat (6) step("mem_timeout");
        memreqM = 0;
        repeat (2) step("mem_err_hold");
        doReset();
        step("mem_err_cleared");

        // Divider busy window and HI/LO read stall
        divstartE = 1;
        step("div_start");
        divstartE = 0;
        for (int k = 1; k <= 10; k++) begin
            mfhiloD = (k >= 3);
            step("div_busy");
        end
        mfhiloD = 0;
        divstartE = 1;
        step("div_start2");
        divstartE = 0;
        repeat (3) step("div_busy2");
        doReset();
        step("div_after_reset");

        // Random traffic
        for (int n = 0; n < 1500; n++) begin
            rst_n = !(($urandom_range(0, 149) == 0) || (errFlag && $urandom_range(0, 3) == 0));
            rsD = REG_W'($urandom_range(0, 7));
            rtD = REG_W'($urandom_range(0, 7));
            rsE = REG_W'($urandom_range(0, 7));
            rtE = REG_W'($urandom_range(0, 7));
            writeregE = REG_W'($urandom_range(0, 7));
            writeregM = REG_W'($urandom_range(0, 7));
            writeregW = REG_W'($urandom_range(0, 7));
            regwriteE = 1'($urandom_range(0, 1));
            regwriteM = 1'($urandom_range(0, 1));
            regwriteW = 1'($urandom_range(0, 1));
            memtoregE = ($urandom_range(0, 3) == 0);
            memtoregM = ($urandom_range(0, 3) == 0);
            branchD   = ($urandom_range(0, 2) == 0);
            divstartE = ($urandom_range(0, 7) == 0);
            mfhiloD   = ($urandom_range(0, 2) == 0);
            if (!inEp && $urandom_range(0, 5) == 0) begin
                inEp = 1;
                memLat = $urandom_range(0, 5);
            end
            if (inEp) begin
                memreqM = 1;
                dmem_ready = (memLat == 0);
                if (memLat == 0) inEp = 0;
                else memLat--;
            end else begin
                memreqM = 0;
                dmem_ready = 1'($urandom_range(0, 1));
            end
            step("random");
        end

        #5;
        vectors++;
        if (expQ.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d predictions left unchecked, expected 0", expQ.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
